// File: rtl/sample_locate.sv
// sample_locate: walks the sample SRAM, drops repeated entries, turns each
// frame word address into an (x, y) pixel-pair coordinate by stepping row by
// row (no divider), and streams the results over valid/ready. It also counts
// accepted outputs and flags entries whose address runs backwards.
module sample_locate #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDR        = 14,
  parameter int PIXNUMWIDTH = 11,
  parameter int NUM_ENTRIES = 1200,
  parameter int ROW_WORDS   = 64,
  parameter int XWIDTH      = 6,
  parameter int YWIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   rd,
  output logic [ADDR-1:0]        raddr,
  input  logic [DATAWIDTH-1:0]   rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XWIDTH-1:0]      out_x,
  output logic [YWIDTH-1:0]      out_y,
  output logic                   out_pol,
  output logic                   busy,
  output logic                   done,
  output logic [PIXNUMWIDTH-1:0] edge_count,
  output logic                   order_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOCATE, S_EMIT, S_DONE
  } state_t;

  localparam logic [ADDR-1:0] LAST_INDEX = ADDR'(NUM_ENTRIES - 1);
  localparam logic [ADDR-1:0] ROW_INC    = ADDR'(ROW_WORDS);
  // One extra bit so the end of the top row does not wrap to zero.
  localparam logic [ADDR:0]   ROW_SPAN   = (ADDR + 1)'(ROW_WORDS);

  state_t                 state, state_next;
  logic [ADDR-1:0]        index;
  logic [DATAWIDTH-1:0]   prev_word;
  logic [ADDR-1:0]        cur_addr;
  logic                   cur_pol;
  logic [ADDR-1:0]        row_base;
  logic [YWIDTH-1:0]      y;

  logic                   dup;
  logic                   last_entry;
  logic                   below_row;
  logic                   beyond_row;
  logic [ADDR:0]          row_end;

  assign dup        = (rdata == prev_word);
  assign last_entry = (index == LAST_INDEX);
  assign row_end    = {1'b0, row_base} + ROW_SPAN;
  assign below_row  = (cur_addr < row_base);
  assign beyond_row = ({1'b0, cur_addr} >= row_end);

  assign rd        = (state == S_REQ);
  assign raddr     = index;
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_REQ;
      S_REQ:          state_next = S_WAIT;
      S_WAIT: begin
        if (dup) state_next = last_entry ? S_DONE : S_REQ;
        else     state_next = S_LOCATE;
      end
      S_LOCATE:       if (!below_row && !beyond_row) state_next = S_EMIT;
      S_EMIT:         if (out_ready) state_next = last_entry ? S_DONE : S_REQ;
      default:        state_next = S_IDLE;
    endcase
  end

  // Datapath: scan index, dedupe word, row walk, output hold and counters.
  // NOTE: every datapath register is in the async reset so a reset mid-scan
  // leaves no stale coordinate or count visible on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index      <= '0;
      prev_word  <= '0;
      cur_addr   <= '0;
      cur_pol    <= 1'b0;
      row_base   <= '0;
      y          <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_pol    <= 1'b0;
      edge_count <= '0;
      order_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            index      <= '0;
            prev_word  <= '0;
            row_base   <= '0;
            y          <= '0;
            edge_count <= '0;
            order_err  <= 1'b0;
          end
        end
        S_WAIT: begin
          cur_addr <= rdata[ADDR-1:0];
          cur_pol  <= rdata[DATAWIDTH-1];
          if (dup) begin
            if (!last_entry) index <= index + ADDR'(1);
          end else begin
            prev_word <= rdata;
          end
        end
        S_LOCATE: begin
          if (below_row) begin
            // Address went backwards: flag it and re-walk from row 0.
            order_err <= 1'b1;
            row_base  <= '0;
            y         <= '0;
          end else if (beyond_row) begin
            row_base <= row_base + ROW_INC;
            y        <= y + YWIDTH'(1);
          end else begin
            out_x   <= XWIDTH'(cur_addr - row_base);
            out_y   <= y;
            out_pol <= cur_pol;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (edge_count != '1) edge_count <= edge_count + PIXNUMWIDTH'(1);
            if (!last_entry) index <= index + ADDR'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_locate.sv
// Directed bench for sample_locate: SRAM model with one-cycle read latency,
// per-scenario tasks with hand-computed expectations.
module tb_sample_locate;

  localparam int NUM = 1200;

  typedef struct packed {
    logic       pol;
    logic [7:0] y;
    logic [5:0] x;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd;
  logic [13:0] raddr;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_x;
  logic [7:0]  out_y;
  logic        out_pol;
  logic        busy;
  logic        done;
  logic [10:0] edge_count;
  logic        order_err;

  logic [31:0] mem [0:NUM-1];
  logic [13:0] rd_addrs [$];
  out_t        outs [$];

  int tests = 0;
  int fails = 0;

  sample_locate dut (
    .clk(clk), .rst(rst), .start(start), .rd(rd), .raddr(raddr),
    .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_pol(out_pol), .busy(busy),
    .done(done), .edge_count(edge_count), .order_err(order_err)
  );

  always #5 clk = ~clk;

  // Sample SRAM: data appears the cycle after rd.
  always @(posedge clk) if (rd) rdata <= mem[raddr];

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rd) rd_addrs.push_back(raddr);
    if (out_valid && out_ready) outs.push_back({out_pol, out_y, out_x});
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < NUM; i++) mem[i] = v;
  endtask

  task automatic clear_obs();
    rd_addrs.delete();
    outs.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
      n++;
    end
  endtask

  function automatic int seq_errors();
    int e = 0;
    if (rd_addrs.size() != NUM) e++;
    foreach (rd_addrs[i]) if (rd_addrs[i] != 14'(i)) e++;
    return e;
  endfunction

  task automatic test_reset();
    tests++;
    if ({busy, done, out_valid, rd} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got busy/done/valid/rd=%b expected 0000", {busy, done, out_valid, rd});
    end
    tests++;
    if (raddr !== 14'd0) begin
      fails++; $display("FAIL reset_raddr: got %0d expected 0", raddr);
    end
    tests++;
    if ({out_pol, out_y, out_x} !== 15'd0) begin
      fails++; $display("FAIL reset_coord: got %h expected 0", {out_pol, out_y, out_x});
    end
    tests++;
    if (edge_count !== 11'd0 || order_err !== 1'b0) begin
      fails++; $display("FAIL reset_counts: got edge=%0d err=%b expected 0/0", edge_count, order_err);
    end
  endtask

  task automatic test_basic();
    bit ok;
    fill_mem(32'h0000_0047);
    mem[0] = 32'h0; mem[1] = 32'h0;
    mem[2] = 32'h8000_0005; mem[3] = 32'h8000_0005;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    run_to_done(10000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: done=%b expected 1", done); end
    tests++;
    if (outs.size() != 2) begin
      fails++; $display("FAIL basic_count: got %0d outputs expected 2", outs.size());
    end else begin
      tests++;
      if (outs[0] !== out_t'{1'b1, 8'd0, 6'd5}) begin
        fails++; $display("FAIL basic_out0: got pol=%b y=%0d x=%0d expected 1/0/5", outs[0].pol, outs[0].y, outs[0].x);
      end
      tests++;
      if (outs[1] !== out_t'{1'b0, 8'd1, 6'd7}) begin
        fails++; $display("FAIL basic_out1: got pol=%b y=%0d x=%0d expected 0/1/7", outs[1].pol, outs[1].y, outs[1].x);
      end
    end
    tests++;
    if (edge_count !== 11'd2) begin
      fails++; $display("FAIL basic_edges: got %0d expected 2", edge_count);
    end
    tests++;
    if (seq_errors() != 0) begin
      fails++; $display("FAIL basic_raddr_seq: %0d reads, %0d errors, expected 1200 in order", rd_addrs.size(), seq_errors());
    end
    tests++;
    if (rd_addrs.size() > 0 && rd_addrs[$] !== 14'd1199) begin
      fails++; $display("FAIL basic_last_raddr: got %0d expected 1199", rd_addrs[$]);
    end
    tests++;
    if ({busy, order_err} !== 2'b00) begin
      fails++; $display("FAIL basic_flags: got busy=%b err=%b expected 0/0", busy, order_err);
    end
  endtask

  task automatic test_far_address();
    bit ok;
    int n;
    fill_mem(32'h0000_3FFF);
    clear_obs();
    out_ready = 1'b0;
    pulse_start();
    wait_valid(400, ok, n);
    tests++;
    if (!ok || n != 258) begin
      fails++; $display("FAIL far_latency: got %0d cycles to valid (LOCATE %0d) expected 258 (LOCATE 256)", n, n - 2);
    end
    tests++;
    if (out_x !== 6'd63 || out_y !== 8'd255 || out_pol !== 1'b0) begin
      fails++; $display("FAIL far_coord: got x=%0d y=%0d pol=%b expected 63/255/0", out_x, out_y, out_pol);
    end
    out_ready = 1'b1;
    run_to_done(10000, ok);
    tests++;
    if (!ok || outs.size() != 1 || edge_count !== 11'd1) begin
      fails++; $display("FAIL far_finish: got done=%b outs=%0d edge=%0d expected 1/1/1", done, outs.size(), edge_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int unstable;
    int rdn;
    logic [14:0] held;
    fill_mem(32'h8000_0085);
    clear_obs();
    out_ready = 1'b0;
    pulse_start();
    wait_valid(50, ok, n);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_valid: out_valid=%b expected 1", out_valid); end
    held     = {out_pol, out_y, out_x};
    rdn      = rd_addrs.size();
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || {out_pol, out_y, out_x} !== held || edge_count !== 11'd0) unstable++;
    end
    tests++;
    if (unstable != 0) begin
      fails++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
    end
    tests++;
    if (rd_addrs.size() != rdn || rdn != 1) begin
      fails++; $display("FAIL bp_no_read: got %0d reads expected 1", rd_addrs.size());
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (edge_count !== 11'd1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_handshake: got edge=%0d valid=%b expected 1/0", edge_count, out_valid);
    end
    tests++;
    if (outs.size() != 1 || outs[0] !== out_t'{1'b1, 8'd2, 6'd5}) begin
      fails++; $display("FAIL bp_value: got %0d outputs first=%h expected 1 output %h", outs.size(), (outs.size() > 0) ? outs[0] : out_t'(0), out_t'{1'b1, 8'd2, 6'd5});
    end
    run_to_done(10000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_done: done=%b expected 1", done); end
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    int n;
    fill_mem(32'h0000_0047);
    mem[0] = 32'h0000_0005;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (outs.size() == 1) begin ok = 1'b1; break; end
      tick();
    end
    out_ready = 1'b0;
    wait_valid(50, ok, n);
    tests++;
    if (!ok || edge_count !== 11'd1) begin
      fails++; $display("FAIL rme_pre: got valid=%b edge=%0d expected 1/1", out_valid, edge_count);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || edge_count !== 11'd0) begin
      fails++; $display("FAIL rme_reset: got valid=%b busy=%b edge=%0d expected 0/0/0", out_valid, busy, edge_count);
    end
    rst = 1'b1;
    tick();
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    run_to_done(10000, ok);
    tests++;
    if (!ok || rd_addrs.size() == 0 || rd_addrs[0] !== 14'd0) begin
      fails++; $display("FAIL rme_rescan_start: got done=%b first raddr=%0d expected 1/0", done, (rd_addrs.size() > 0) ? rd_addrs[0] : 14'h3FFF);
    end
    tests++;
    if (seq_errors() != 0 || outs.size() != 2) begin
      fails++; $display("FAIL rme_rescan: got %0d reads %0d outputs expected 1200/2", rd_addrs.size(), outs.size());
    end
  endtask

  task automatic test_order_err();
    bit ok;
    fill_mem(32'h0000_0010);
    mem[0] = 32'h0000_0100;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    run_to_done(10000, ok);
    tests++;
    if (!ok || outs.size() != 2) begin
      fails++; $display("FAIL order_count: got done=%b outputs=%0d expected 1/2", done, outs.size());
    end else begin
      tests++;
      if (outs[0] !== out_t'{1'b0, 8'd4, 6'd0}) begin
        fails++; $display("FAIL order_out0: got y=%0d x=%0d expected 4/0", outs[0].y, outs[0].x);
      end
      tests++;
      if (outs[1] !== out_t'{1'b0, 8'd0, 6'd16}) begin
        fails++; $display("FAIL order_out1: got y=%0d x=%0d expected 0/16", outs[1].y, outs[1].x);
      end
    end
    tests++;
    if (order_err !== 1'b1) begin
      fails++; $display("FAIL order_flag: got %b expected 1", order_err);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    fill_mem(32'h0000_0047);
    mem[0] = 32'h0000_0005;
    clear_obs();
    out_ready = 1'b1;
    tick();
    tests++;
    if (order_err !== 1'b1 || done !== 1'b1) begin
      fails++; $display("FAIL si_sticky: got err=%b done=%b expected 1/1", order_err, done);
    end
    pulse_start();
    tests++;
    if (order_err !== 1'b0 || edge_count !== 11'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL si_restart: got err=%b edge=%0d busy=%b expected 0/0/1", order_err, edge_count, busy);
    end
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 37; i++) tick();
      pulse_start();
    end
    run_to_done(10000, ok);
    tests++;
    if (!ok || seq_errors() != 0) begin
      fails++; $display("FAIL si_raddr_seq: got done=%b reads=%0d errors=%0d expected 1/1200/0", done, rd_addrs.size(), seq_errors());
    end
    tests++;
    if (outs.size() != 2 || edge_count !== 11'd2) begin
      fails++; $display("FAIL si_outputs: got %0d outputs edge=%0d expected 2/2", outs.size(), edge_count);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    fill_mem(32'h0);
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_basic();
    test_far_address();
    test_backpressure();
    test_reset_mid_emit();
    test_order_err();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_locate.md
Name: sample_locate

Overview:
- Stage directly downstream of the sampling stage.
- Scans the sample SRAM that the sampling stage filled. Each entry is {pol, 17'd0, frame_word_addr[13:0]}.
- Drops repeated entries, converts each frame word address to an (x, y) coordinate of the pixel pair, and streams the results over a valid/ready interface.
- Also counts emitted edges and flags address-order violations.

Parameters:
- DATAWIDTH, 32, sample SRAM word width.
- ADDR, 14, sample/frame SRAM address width.
- PIXNUMWIDTH, 11, width of entry count.
- NUM_ENTRIES, 1200, sample SRAM entries to scan.
- ROW_WORDS, 64, frame words per image row (2 pixels per word).
- XWIDTH, 6, width of out_x (holds ROW_WORDS-1).
- YWIDTH, 8, width of out_y.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  one-cycle pulse; begins a scan from IDLE. Ignored otherwise.
- rd  out  1  sample SRAM read enable.
- raddr  out  ADDR  sample SRAM read address.
- rdata  in  DATAWIDTH  sample SRAM read data, valid the cycle after rd.
- out_valid  out  1  coordinate available.
- out_ready  in  1  consumer accepts.
- out_x  out  XWIDTH  word column (addr mod ROW_WORDS).
- out_y  out  YWIDTH  row (addr / ROW_WORDS).
- out_pol  out  1  rdata[31] of the entry.
- busy  out  1  high outside IDLE and DONE.
- done  out  1  high in DONE.
- edge_count  out  PIXNUMWIDTH  number of accepted outputs in this scan.
- order_err  out  1  sticky; set when an entry address is below the current row base.

Behaviour:
- Reset (rst=0, any time, including mid-scan): state IDLE; all outputs 0; prev_word = 0; row_base = 0; y = 0; entry index = 0. No transaction is pending after reset release.
- States: IDLE, REQ, WAIT, LOCATE, EMIT, DONE.
- IDLE:
  - start=1 → REQ.
  - On entry from start: edge_count, order_err, index, row_base, y, prev_word all cleared.
- REQ:
  - rd=1 for exactly one cycle, raddr = index → WAIT.
- WAIT:
  - Capture rdata into cur_word.
  - If cur_word == prev_word, the entry is a duplicate → NEXT handling.
  - Else prev_word <= cur_word → LOCATE.
  - Because prev_word starts at 0, leading all-zero entries are skipped.
- LOCATE:
  - a = cur_word[ADDR-1:0].
  - If a < row_base: set order_err, row_base <= 0, y <= 0, stay in LOCATE. This re-walks from row 0.
  - Else if a >= row_base + ROW_WORDS: row_base += ROW_WORDS, y += 1, stay. One row per cycle.
  - Else: out_x = a - row_base, out_y = y, out_pol = cur_word[31] → EMIT.
  - No divider is used. Latency is 1 cycle plus rows advanced.
- EMIT:
  - out_valid=1; out_x/out_y/out_pol held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: edge_count += 1 (saturates at all-ones) → NEXT handling.
  - out_valid never drops without a handshake.
- NEXT handling:
  - If index == NUM_ENTRIES-1 → DONE.
  - Else index += 1 → REQ.
  - Entries 0..NUM_ENTRIES-1 are read exactly once.
- DONE:
  - done=1, held until start=1, which restarts the scan directly into REQ with all counters cleared.
- y overflow: y wraps modulo 2^YWIDTH. No error is raised for this.
- Minimum per-entry cost: 4 cycles (REQ, WAIT, LOCATE, EMIT with ready=1). A duplicate costs 2 cycles.

Test Plan:
- Reset mid-EMIT with out_ready=0 → next cycle out_valid=0, busy=0, edge_count=0; a subsequent start rescans from raddr=0.
- SRAM entries [0x0, 0x0, 0x80000005, 0x80000005, 0x00000047], rest equal to the last entry → exactly 2 outputs:
  - (x=5, y=0, pol=1)
  - (x=7, y=1, pol=0)
  - edge_count=2, done after all NUM_ENTRIES reads (raddr reaches 1199).
- Entry address 0x3FFF with ROW_WORDS=64 → out_x=63, out_y=255; LOCATE takes 256 cycles.
- Backpressure: hold out_ready=0 for 10 cycles during EMIT → outputs stable, no new rd pulse, edge_count unchanged until the handshake.
- Entries 0x00000100 then 0x00000010 → second output x=16, y=0; order_err=1 and stays 1 until the next start.
- start pulsed while busy → ignored; raddr sequence is unchanged.
